ahb_slave_mem: RTL
==================

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AHB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AHB data width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0-7, number of hreadyout-low cycles inserted per data phase.
REQ-005 SHALL have port hclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port hresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port hsel, input, 1, slave select.
REQ-008 SHALL have port haddr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have port htrans, input, 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 SHALL have port hwrite, input, 1: 1=write, 0=read.
REQ-011 SHALL have port hsize, input, 3: 0=byte, 1=half, 2=word.
REQ-012 SHALL have port hburst, input, 3, burst type; accepted but not used functionally.
REQ-013 SHALL have port hwdata, input, DATA_WIDTH, write data, valid in the data phase.
REQ-014 SHALL have port hreadyin, input, 1, bus-level HREADY.
REQ-015 SHALL have port hrdata, output, DATA_WIDTH, read data.
REQ-016 SHALL have port hreadyout, output, 1, data-phase completion.
REQ-017 SHALL have port hresp, output, 2: OKAY=2'b00, ERROR=2'b01.

Function
REQ-018 SHALL capture an address phase when hsel & hreadyin & htrans[1] at the clock edge, registering haddr, hwrite and hsize.
REQ-019 SHALL answer IDLE, BUSY and unselected transfers with an OKAY, zero-wait response and no memory access.
REQ-020 SHALL implement the FSM states S_IDLE, S_WAIT, S_DATA, S_ERR1 and S_ERR2.
REQ-021 On capture, the FSM SHALL enter S_WAIT when WAIT_STATES>0, otherwise S_DATA.
REQ-022 In S_WAIT, hreadyout SHALL be 0 while a down-counter runs for WAIT_STATES cycles; the FSM SHALL then enter S_DATA.
REQ-023 In S_DATA, hreadyout SHALL be 1 and hresp OKAY.
REQ-024 From S_DATA, the FSM SHALL go to S_WAIT, S_DATA or S_ERR1 if a new phase is captured in the same cycle, else to S_IDLE.
REQ-025 Writes SHALL commit hwdata on the S_DATA edge, using little-endian byte lanes selected by hsize and haddr[1:0]; unselected lanes are unchanged.
REQ-026 Reads SHALL drive hrdata combinationally in S_DATA from the registered word address, as the full word with all lanes valid; hrdata SHALL be 0 outside S_DATA.
REQ-027 Back-to-back write then read of the same address SHALL return the new data, with no extra stall.
REQ-028 Word index SHALL be haddr[ADDR_WIDTH-1:2]; incrementing bursts need no internal address generation.

Reset
REQ-029 Asserting hresetn low SHALL force hreadyout=1, hresp=OKAY, hrdata=0, FSM=S_IDLE and the wait counter to 0.
REQ-030 Reset mid-transfer SHALL discard any pending write.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 The macro AHB_SLAVE_ERR_EN SHALL control error responses.
REQ-033 When AHB_SLAVE_ERR_EN is defined, the ERROR conditions SHALL be: word index >= MEM_DEPTH, misalignment (half with addr[0]=1, word with addr[1:0]!=0), or hsize>2.
REQ-034 On an ERROR condition with AHB_SLAVE_ERR_EN defined, the block SHALL skip wait states and enter S_ERR1 (hresp=ERROR, hreadyout=0), then S_ERR2 (hresp=ERROR, hreadyout=1), with no memory write.
REQ-035 When AHB_SLAVE_ERR_EN is undefined, hresp SHALL be tied to OKAY.
REQ-036 When AHB_SLAVE_ERR_EN is undefined, the word index SHALL wrap modulo MEM_DEPTH and misaligned addresses SHALL be aligned down.

Structure
REQ-037 Package ahb_pkg SHALL hold the HTRANS, HSIZE, HBURST and HRESP encodings and the FSM state typedef.
REQ-038 Sub-module ahb_slave_mem_ram SHALL hold the MEM_DEPTH x 32 array, with a 4-bit byte-write-enable and an asynchronous read port.

Verification
REQ-039 Single word write, then read: write 0xDEADBEEF to 0x10, read 0x10 -> hrdata=0xDEADBEEF, hresp=OKAY, each data phase 1 cycle (WAIT_STATES=0).
REQ-040 Byte/half lanes: word at 0x20=0, then byte write 0xAA to 0x21 and half write 0x1234 to 0x22 -> read 0x20 returns 0x1234AA00.
REQ-041 INCR4 burst: with WAIT_STATES=2, write 0x1,0x2,0x3,0x4 from 0x40 -> each beat sees 2 hreadyout-low cycles; read back 1,2,3,4.
REQ-042 Error (AHB_SLAVE_ERR_EN defined, MEM_DEPTH=256): write to 0x400 -> 2-cycle ERROR, memory unchanged; without the macro, read 0x400 returns word 0.
REQ-043 Reset mid-write: assert hresetn during the S_WAIT of a write to 0x50 -> outputs at reset values, 0x50 keeps its old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and the ahb_slave_mem FSM state type.
//   htrans_e / hsize_e / hburst_e / hresp_e : AHB-Lite field encodings
//   state_e                                 : slave data-phase FSM states
//   byte_en()                               : little-endian lane enables from
//                                             hsize and haddr[1:0]
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  // Misaligned halfwords fall onto the lower/upper lane pair containing them;
  // sizes above word are treated as full-word accesses.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << off;
      HSIZE_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem_ram.sv
// ahb_slave_mem_ram: DEPTH x DW word store with per-byte write enables.
//   clk   : write clock (rising edge)
//   addr  : word index, shared by the write and the asynchronous read port
//   we    : byte-lane write enables, bit i writes wdata[8i+7:8i]
//   wdata : write data
//   rdata : asynchronous read of mem[addr]
// Contents are intentionally not reset.
module ahb_slave_mem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave backed by a MEM_DEPTH x 32 memory.
//   hclk/hresetn   : clock, asynchronous active-low reset
//   hsel, haddr, htrans, hwrite, hsize, hburst, hreadyin : address phase
//   hwdata         : write data (data phase)
//   hrdata, hreadyout, hresp : data-phase response
// Optional macro AHB_SLAVE_ERR_EN: out-of-range, misaligned or oversize
// accesses get a two-cycle ERROR response. Without it hresp is always OKAY,
// the word index wraps modulo MEM_DEPTH and misaligned addresses align down.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hreadyin,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] DEPTH_W = IW'(MEM_DEPTH);

  state_e          state_q, state_d, entry_state;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   widx_q, widx_d, widx_new;
  logic [3:0]      be_q, be_d;
  logic            write_q, write_d;
  logic [IW-1:0]   word_a;
  logic            addr_err, accept;
  logic [3:0]      mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic            unused_hburst;

  assign unused_hburst = ^hburst;
  assign word_a = haddr[ADDR_WIDTH-1:2];

`ifdef AHB_SLAVE_ERR_EN
  assign addr_err = (word_a >= DEPTH_W)
                 || ((hsize == HSIZE_HALF) && haddr[0])
                 || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                 || (hsize > HSIZE_WORD);
  assign widx_new = AW'(word_a);
`else
  assign addr_err = 1'b0;
  assign widx_new = AW'(word_a % DEPTH_W);
`endif

  // Only states that present hreadyout=1 may accept a new address phase.
  assign accept = hsel && hreadyin && htrans[1]
               && (state_q inside {S_IDLE, S_DATA, S_ERR2});

  always_comb begin
    if (addr_err)             entry_state = S_ERR1;
    else if (WAIT_STATES > 0) entry_state = S_WAIT;
    else                      entry_state = S_DATA;
  end

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      be_q    <= be_d;
      write_q <= write_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    be_d    = be_q;
    write_d = write_q;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        state_d = accept ? entry_state : S_IDLE;
        cnt_d   = (accept && entry_state == S_WAIT) ? 3'(WAIT_STATES) : '0;
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      widx_d  = widx_new;
      be_d    = byte_en(hsize, haddr[1:0]);
      write_d = hwrite;
    end
  end

  // Output logic
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = '0;
    mem_we    = '0;
    case (state_q)
      S_WAIT: hreadyout = 1'b0;
      S_DATA: begin
        hrdata = mem_rdata;
        if (write_q) mem_we = be_q;
      end
`ifdef AHB_SLAVE_ERR_EN
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      S_ERR2: hresp = HRESP_ERROR;
`else
      S_ERR1: hreadyout = 1'b0;
`endif
      default: ;
    endcase
  end

  ahb_slave_mem_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW),
    .DW    (DATA_WIDTH)
  ) u_ram (
    .clk   (hclk),
    .addr  (widx_q),
    .we    (mem_we),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

endmodule
